booth_radix4_seq_mult: RTL and testbench

//   Iterative radix-4 Booth multiplier, parametrised in operand width, with signed/unsigned mode.

---
 rtl/booth_radix4_seq_mult.sv | 127 ++++++++++++
 tb/tb_booth_radix4_seq_mult.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_seq_mult.sv
// booth_radix4_seq_mult: iterative radix-4 Booth multiplier, signed or unsigned operands.
// Latency: STEPS = WIDTH/2+1 RUN cycles after the accepting edge, then a one-cycle done pulse.
// Backpressure: ready=0 while running; start is ignored until ready returns (DONE accepts).
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start, op_signed   request (sampled when ready=1) and operand interpretation
//   multiplicand       M operand, multiplier Q operand (both registered at accept)
//   ready, busy, done  idle/accepting, in progress, one-cycle result-valid pulse
//   product            2*WIDTH result, held until the next product is written
module booth_radix4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int EW    = WIDTH + 2;   // extended operand width
  localparam int AW    = WIDTH + 4;   // accumulator width, holds +/-2M without overflow
  localparam int STEPS = EW / 2;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [EW-1:0]        m_q, m_d;
  logic [AW-1:0]        a_q, a_d;
  logic [EW-1:0]        q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [AW-1:0]        m_aw;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        a_sum;
  logic [AW-1:0]        a_next;
  logic [EW-1:0]        q_next;
  logic                 m_sgn, q_sgn;

  // Datapath for one Booth digit; only consumed in RUN.
  always_comb begin
    m_aw = {{2{m_q[EW-1]}}, m_q};
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: addend = m_aw;
      3'b011:         addend = {m_aw[AW-2:0], 1'b0};
      3'b100:         addend = AW'(0) - {m_aw[AW-2:0], 1'b0};
      3'b101, 3'b110: addend = AW'(0) - m_aw;
      default:        addend = '0;
    endcase
    a_sum  = a_q + addend;
    // Arithmetic shift of {A,Q,q_m1} right by two.
    a_next = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
    q_next = {a_sum[1:0], q_q[EW-1:2]};
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    // Unsigned operands zero-extend, so the extra top bits keep them positive.
    m_sgn     = op_signed & multiplicand[WIDTH-1];
    q_sgn     = op_signed & multiplier[WIDTH-1];
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          m_d     = {{2{m_sgn}}, multiplicand};
          q_d     = {{2{q_sgn}}, multiplier};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_d   = a_next;
        q_d   = q_next;
        qm1_d = q_q[1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d   = S_DONE;
          product_d = {a_next[2*WIDTH-EW-1:0], q_next};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign ready   = (state_q != S_RUN);
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// tb_booth_radix4_seq_mult: randomized and directed checks of the Booth multiplier against a.b arithmetic.
// Latency: done expected on the 5th edge after the accepting edge (WIDTH=8), pulses 6 cycles apart.
// Backpressure: starts during RUN are exercised and must be ignored.
module tb_booth_radix4_seq_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           op_signed;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] last_prod;

  booth_radix4_seq_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op_signed    (op_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the mathematical product, truncated to 2*W bits.
  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int av, bv, p;
    av = s ? int'($signed(a)) : int'({24'd0, a});
    bv = s ? int'($signed(b)) : int'({24'd0, b});
    p  = av * bv;
    return p[2*W-1:0];
  endfunction

  // Called at a negedge with the DUT ready; returns at the negedge where done is seen.
  // poke=1 fires a start with junk operands mid-run, which must be ignored.
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp, input bit poke);
    int n;
    start = 1'b1; op_signed = s; multiplicand = a; multiplier = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    multiplicand = W'($urandom); multiplier = W'($urandom); op_signed = 1'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      chk({tag, "_hold"}, product, last_prod);
      chk({tag, "_busy"}, busy, 1'b1);
      if (poke) chk({tag, "_rdy_run"}, ready, 1'b0);
      if (poke && n == 2) begin
        start = 1'b1; op_signed = 1'b0; multiplicand = 8'h11; multiplier = 8'h22;
      end
      if (poke && n == 3) start = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, n, 5);
    chk({tag, "_prod"}, product, exp);
    last_prod = exp;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           m;
    bit           saw_done;

    rst = 1'b1; start = 1'b0; op_signed = 1'b0; multiplicand = '0; multiplier = '0;
    last_prod = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_prod", product, '0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases, each followed by a single-cycle done check.
    run_op("s_m128sq", 1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);
    @(negedge clk); chk("s_m128sq_pulse", done, 1'b0);
    run_op("u_ffsq", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    @(negedge clk); chk("u_ffsq_pulse", done, 1'b0);
    run_op("s_m1sq", 1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0);
    @(negedge clk);
    run_op("s_m128x127", 1'b1, 8'h80, 8'h7F, 16'hC080, 1'b0);
    @(negedge clk);
    run_op("s_7xm3", 1'b1, 8'h07, 8'hFD, 16'hFFEB, 1'b0);
    @(negedge clk);
    run_op("u_0x5a", 1'b0, 8'h00, 8'h5A, 16'h0000, 1'b0);
    @(negedge clk);
    run_op("ignore_start", 1'b1, 8'h07, 8'hFD, 16'hFFEB, 1'b1);
    @(negedge clk);

    // Reset three cycles into RUN aborts with no done and clears product.
    start = 1'b1; op_signed = 1'b0; multiplicand = 8'hC3; multiplier = 8'h9A;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_prod", product, '0);
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 1'b0);
    last_prod = '0;
    run_op("after_abort", 1'b0, 8'hC3, 8'h9A, model(1'b0, 8'hC3, 8'h9A), 1'b0);
    @(negedge clk);

    // Back-to-back: start held high, second op accepted in the DONE cycle.
    start = 1'b1; op_signed = 1'b1; multiplicand = 8'h85; multiplier = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    op_signed = 1'b0; multiplicand = 8'hE7; multiplier = 8'hB2;
    m = 0;
    while (done !== 1'b1 && m < 20) begin
      @(posedge clk); m++; @(negedge clk);
    end
    chk("b2b_lat1", m, 5);
    chk("b2b_prod1", product, model(1'b1, 8'h85, 8'h3C));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy2", busy, 1'b1);
    m = 1;
    while (done !== 1'b1 && m < 20) begin
      @(posedge clk); m++; @(negedge clk);
    end
    chk("b2b_gap", m, 6);
    chk("b2b_prod2", product, model(1'b0, 8'hE7, 8'hB2));
    last_prod = product;
    @(negedge clk);

    // Random sweep, both modes, issuing each op in the previous DONE cycle.
    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      run_op("rand", rs, ra, rb, model(rs, ra, rb), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
